// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback states, handshakes with a shared memory and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned ALU_CTRL_W     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32,
  parameter bit          TRAP_HALT      = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  input  logic                  i_zero,
  input  logic                  i_mem_ready,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_mem_half,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic                  o_pc_src,
  output logic                  o_alu_src,
  output logic [ALU_CTRL_W-1:0] o_alu_control,
  output logic                  o_reg_write,
  output logic [1:0]            o_wb_sel,
  output logic                  o_illegal,
  output logic                  o_bus_error,
  output logic [3:0]            o_state,
  output logic [CNT_W-1:0]      o_retired
);

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_EXEC_R = 4'd2;
  localparam logic [3:0] ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_WB_ALU = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WR = 4'd6;
  localparam logic [3:0] ST_BRANCH = 4'd7;
  localparam logic [3:0] ST_JAL    = 4'd8;
  localparam logic [3:0] ST_TRAP   = 4'd9;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LH  = 7'b0001011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_SH  = 7'b0101011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0001);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0011);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(4'b0101);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [3:0]        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retired;
  logic              r_illegal;
  logic              r_bus_error;

  logic [3:0]        w_state_d;
  logic [WAIT_W-1:0] w_wait_d;
  logic              w_retire;
  logic              w_trap_ill;
  logic              w_trap_bus;
  logic              w_r_legal;
  logic              w_i_legal;
  logic              w_br_legal;
  logic              w_br_taken;
  logic              w_access;
  logic              w_timeout;

  always_comb begin
    w_r_legal  = ((i_funct3 == 3'b000) && ((i_funct7 == 7'b0000000) || (i_funct7 == 7'b0100000)))
                 || (i_funct3 == 3'b110) || (i_funct3 == 3'b001);
    w_i_legal  = (i_funct3 == 3'b000) || (i_funct3 == 3'b111);
    w_br_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001);
    w_br_taken = ((i_funct3 == 3'b001) && !i_zero) || ((i_funct3 == 3'b000) && i_zero);
    w_access   = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    // A ready on the last allowed wait cycle still completes the access.
    w_timeout  = (TIMEOUT_CYCLES != 0) && w_access && !i_mem_ready
                 && (32'(r_wait) == TIMEOUT_CYCLES - 1);
  end

  always_comb begin
    w_state_d  = r_state;
    w_retire   = 1'b0;
    w_trap_ill = 1'b0;
    w_trap_bus = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (i_mem_ready) w_state_d = ST_DECODE;
        else if (w_timeout) begin
          w_state_d  = ST_TRAP;
          w_trap_bus = 1'b1;
        end
      end
      ST_DECODE: begin
        case (i_opcode)
          OP_R:         w_state_d = ST_EXEC_R;
          OP_I:         w_state_d = ST_EXEC_I;
          OP_LH:        w_state_d = ST_MEM_RD;
          OP_SW, OP_SH: w_state_d = ST_MEM_WR;
          OP_BR:        w_state_d = ST_BRANCH;
          OP_JAL:       w_state_d = ST_JAL;
          default: begin
            w_state_d  = ST_TRAP;
            w_trap_ill = 1'b1;
          end
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: begin
        if ((r_state == ST_EXEC_R) ? w_r_legal : w_i_legal) w_state_d = ST_WB_ALU;
        else begin
          w_state_d  = ST_TRAP;
          w_trap_ill = 1'b1;
        end
      end
      ST_WB_ALU, ST_JAL: begin
        w_state_d = ST_FETCH;
        w_retire  = 1'b1;
      end
      ST_MEM_RD, ST_MEM_WR: begin
        if (i_mem_ready) begin
          w_state_d = ST_FETCH;
          w_retire  = 1'b1;
        end else if (w_timeout) begin
          w_state_d  = ST_TRAP;
          w_trap_bus = 1'b1;
        end
      end
      ST_BRANCH: begin
        if (w_br_legal) begin
          w_state_d = ST_FETCH;
          w_retire  = 1'b1;
        end else begin
          w_state_d  = ST_TRAP;
          w_trap_ill = 1'b1;
        end
      end
      ST_TRAP: w_state_d = TRAP_HALT ? ST_TRAP : ST_FETCH;
      default: w_state_d = ST_FETCH;
    endcase

    if (w_state_d != r_state)          w_wait_d = '0;
    else if (w_access && !i_mem_ready) w_wait_d = r_wait + 1'b1;
    else                               w_wait_d = r_wait;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_FETCH;
      r_wait      <= '0;
      r_retired   <= '0;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wait      <= w_wait_d;
      r_illegal   <= w_trap_ill;
      r_bus_error <= w_trap_bus;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_half    = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_pc_src      = 1'b0;
    o_alu_src     = 1'b0;
    o_alu_control = ALU_ADD;
    o_reg_write   = 1'b0;
    o_wb_sel      = 2'b00;
    o_illegal     = 1'b0;
    o_bus_error   = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_FETCH: begin
          o_mem_req  = 1'b1;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
        end
        ST_EXEC_R: begin
          if (i_funct3 == 3'b000 && i_funct7 == 7'b0100000) o_alu_control = ALU_SUB;
          else if (i_funct3 == 3'b110)                      o_alu_control = ALU_OR;
          else if (i_funct3 == 3'b001)                      o_alu_control = ALU_SLL;
        end
        ST_EXEC_I: begin
          o_alu_src = 1'b1;
          if (i_funct3 == 3'b111) o_alu_control = ALU_AND;
        end
        ST_WB_ALU: o_reg_write = 1'b1;
        ST_MEM_RD: begin
          o_alu_src  = 1'b1;
          o_mem_req  = 1'b1;
          o_mem_half = 1'b1;
          if (i_mem_ready) begin
            o_reg_write = 1'b1;
            o_wb_sel    = 2'b01;
          end
        end
        ST_MEM_WR: begin
          o_alu_src  = 1'b1;
          o_mem_req  = 1'b1;
          o_mem_we   = 1'b1;
          o_mem_half = (i_opcode == OP_SH);
        end
        ST_BRANCH: begin
          o_alu_control = ALU_SUB;
          if (w_br_legal && w_br_taken) begin
            o_pc_write = 1'b1;
            o_pc_src   = 1'b1;
          end
        end
        ST_JAL: begin
          o_pc_write  = 1'b1;
          o_pc_src    = 1'b1;
          o_reg_write = 1'b1;
          o_wb_sel    = 2'b10;
        end
        ST_TRAP: begin
          o_illegal   = r_illegal;
          o_bus_error = r_bus_error;
        end
        default: ;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into its expected
// per-cycle output timeline from the instruction-level rules and compared cycle by cycle.
module tb_multicycle_control_unit;

  localparam int TMO = 16;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_BRANCH = 4'd7;
  localparam logic [3:0] S_JAL = 4'd8, S_TRAP = 4'd9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LH = 7'b0001011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_SH = 7'b0101011, OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010;
  localparam logic [3:0] A_OR = 4'b0011, A_SLL = 4'b0101;

  // Strobe bit positions: req we half irw pcw pcs asrc
  localparam logic [6:0] B_NONE = 7'b0000000, B_REQ = 7'b1000000, B_WE = 7'b0100000;
  localparam logic [6:0] B_HALF = 7'b0010000, B_IRW = 7'b0001000, B_PCW = 7'b0000100;
  localparam logic [6:0] B_PCS = 7'b0000010, B_ASRC = 7'b0000001;

  logic clk = 1'b0;
  logic rst, rst_h, zero, ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic m_req, m_we, m_half, m_irw, m_pcw, m_pcs, m_asrc, m_rw, m_ill, m_berr;
  logic h_req, h_we, h_half, h_irw, h_pcw, h_pcs, h_asrc, h_rw, h_ill, h_berr;
  logic [3:0] m_alu, h_alu, m_state, h_state;
  logic [1:0] m_wb, h_wb;
  logic [31:0] m_retired, h_retired;
  logic [19:0] m_vec, h_vec;

  int n_checks = 0;
  int n_errors = 0;
  int model_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .ALU_CTRL_W(4), .TIMEOUT_CYCLES(TMO), .CNT_W(32), .TRAP_HALT(1'b0)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_zero(zero), .i_mem_ready(ready), .o_mem_req(m_req), .o_mem_we(m_we),
    .o_mem_half(m_half), .o_ir_write(m_irw), .o_pc_write(m_pcw), .o_pc_src(m_pcs),
    .o_alu_src(m_asrc), .o_alu_control(m_alu), .o_reg_write(m_rw), .o_wb_sel(m_wb),
    .o_illegal(m_ill), .o_bus_error(m_berr), .o_state(m_state), .o_retired(m_retired)
  );

  multicycle_control_unit #(
    .ALU_CTRL_W(4), .TIMEOUT_CYCLES(TMO), .CNT_W(32), .TRAP_HALT(1'b1)
  ) u_halt (
    .i_clk(clk), .i_rst(rst_h), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .i_zero(zero), .i_mem_ready(ready), .o_mem_req(h_req), .o_mem_we(h_we),
    .o_mem_half(h_half), .o_ir_write(h_irw), .o_pc_write(h_pcw), .o_pc_src(h_pcs),
    .o_alu_src(h_asrc), .o_alu_control(h_alu), .o_reg_write(h_rw), .o_wb_sel(h_wb),
    .o_illegal(h_ill), .o_bus_error(h_berr), .o_state(h_state), .o_retired(h_retired)
  );

  assign m_vec = {m_state, m_req, m_we, m_half, m_irw, m_pcw, m_pcs, m_asrc, m_alu, m_rw, m_wb,
                  m_ill, m_berr};
  assign h_vec = {h_state, h_req, h_we, h_half, h_irw, h_pcw, h_pcs, h_asrc, h_alu, h_rw, h_wb,
                  h_ill, h_berr};

  function automatic logic [19:0] ev(input logic [3:0] st, input logic [6:0] strb,
                                     input logic [3:0] alu, input logic rw, input logic [1:0] wb,
                                     input logic ill, input logic berr);
    return {st, strb, alu, rw, wb, ill, berr};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // rdy: 0/1 drive that value, 2 drive a random value (cycle without a request)
  task automatic cyc(input string tag, input logic [19:0] exp, input int rdy, input bit use_h);
    ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
    @(negedge clk);
    check_eq(tag, use_h ? {12'd0, h_vec} : {12'd0, m_vec}, {12'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic trap_cyc(input string tag, input logic ill, input logic berr);
    cyc(tag, ev(S_TRAP, B_NONE, A_ADD, 1'b0, 2'b00, ill, berr), 2, 1'b0);
  endtask

  // Emits the wait cycles of one access; done=0 means it timed out into TRAP.
  task automatic access(input string tag, input logic [19:0] base, input int dly,
                        output bit done);
    int w = (dly < TMO) ? dly : TMO;
    for (int k = 0; k < w; k++) cyc(tag, base, 0, 1'b0);
    done = (dly < TMO);
    if (!done) trap_cyc({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic z, input int fd, input int md);
    bit done;
    bit legal;
    logic [3:0] alu;
    logic [19:0] base;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    zero   = z;
    access("fetch_wait", ev(S_FETCH, B_REQ, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), fd, done);
    if (done) begin
      cyc("fetch", ev(S_FETCH, B_REQ | B_IRW | B_PCW, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1, 1'b0);
      cyc("decode", ev(S_DECODE, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
      if (op == OP_R || op == OP_I) begin
        legal = 1'b0;
        alu = A_ADD;
        if (op == OP_R) begin
          if (f3 == 3'd0 && f7 == 7'h00) legal = 1'b1;
          if (f3 == 3'd0 && f7 == 7'h20) begin legal = 1'b1; alu = A_SUB; end
          if (f3 == 3'd6) begin legal = 1'b1; alu = A_OR; end
          if (f3 == 3'd1) begin legal = 1'b1; alu = A_SLL; end
          cyc("exec_r", ev(S_EXEC_R, B_NONE, alu, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
        end else begin
          if (f3 == 3'd0) legal = 1'b1;
          if (f3 == 3'd7) begin legal = 1'b1; alu = A_AND; end
          cyc("exec_i", ev(S_EXEC_I, B_ASRC, alu, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
        end
        if (legal) begin
          cyc("wb_alu", ev(S_WB_ALU, B_NONE, A_ADD, 1'b1, 2'b00, 1'b0, 1'b0), 2, 1'b0);
          model_ret++;
        end else trap_cyc("trap_exec", 1'b1, 1'b0);
      end else if (op == OP_LH) begin
        base = ev(S_MEM_RD, B_REQ | B_HALF | B_ASRC, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0);
        access("mem_rd_wait", base, md, done);
        if (done) begin
          cyc("mem_rd", ev(S_MEM_RD, B_REQ | B_HALF | B_ASRC, A_ADD, 1'b1, 2'b01, 1'b0, 1'b0),
              1, 1'b0);
          model_ret++;
        end
      end else if (op == OP_SW || op == OP_SH) begin
        base = ev(S_MEM_WR, B_REQ | B_WE | B_ASRC | ((op == OP_SH) ? B_HALF : B_NONE), A_ADD,
                  1'b0, 2'b00, 1'b0, 1'b0);
        access("mem_wr_wait", base, md, done);
        if (done) begin
          cyc("mem_wr", base, 1, 1'b0);
          model_ret++;
        end
      end else if (op == OP_BR) begin
        if (f3 == 3'd0 || f3 == 3'd1) begin
          // BEQ takes on zero, BNE on non-zero
          legal = ((f3 == 3'd0) == z);
          cyc("branch", ev(S_BRANCH, legal ? (B_PCW | B_PCS) : B_NONE, A_SUB, 1'b0, 2'b00,
                           1'b0, 1'b0), 2, 1'b0);
          model_ret++;
        end else begin
          cyc("branch_bad", ev(S_BRANCH, B_NONE, A_SUB, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
          trap_cyc("trap_branch", 1'b1, 1'b0);
        end
      end else if (op == OP_JAL) begin
        cyc("jal", ev(S_JAL, B_PCW | B_PCS, A_ADD, 1'b1, 2'b10, 1'b0, 1'b0), 2, 1'b0);
        model_ret++;
      end else begin
        trap_cyc("trap_opcode", 1'b1, 1'b0);
      end
    end
    check_eq("retired", m_retired, 32'(model_ret));
  endtask

  task automatic rand_instr();
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sel = int'($urandom_range(0, 7));
    bit pick_legal = ($urandom_range(0, 3) != 0);
    int fd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 18))
                                         : int'($urandom_range(0, 2));
    int md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 18))
                                         : int'($urandom_range(0, 3));
    int r7 = int'($urandom_range(0, 5));
    f3 = 3'($urandom_range(0, 7));
    f7 = (r7 < 3) ? 7'h00 : (r7 < 5) ? 7'h20 : 7'($urandom_range(0, 127));
    case (sel)
      0: begin op = OP_R; if (pick_legal) f3 = (r7 < 2) ? 3'd0 : (r7 < 4) ? 3'd6 : 3'd1; end
      1: begin op = OP_I; if (pick_legal) f3 = (r7 < 3) ? 3'd0 : 3'd7; end
      2: op = OP_LH;
      3: op = OP_SW;
      4: op = OP_SH;
      5: begin op = OP_BR; if (pick_legal) f3 = 3'(r7 & 1); end
      6: op = OP_JAL;
      default: begin
        op = 7'($urandom_range(0, 127));
        if (op inside {OP_R, OP_I, OP_LH, OP_SW, OP_SH, OP_BR, OP_JAL}) op = 7'h7F;
      end
    endcase
    do_instr(op, f3, f7, 1'($urandom_range(0, 1)), fd, md);
  endtask

  initial begin
    rst = 1'b1; rst_h = 1'b1; zero = 1'b0; ready = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    @(posedge clk);
    #1;
    cyc("reset", ev(S_FETCH, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1, 1'b0);
    cyc("reset", ev(S_FETCH, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
    check_eq("reset_retired", m_retired, 32'd0);
    rst = 1'b0;

    do_instr(OP_R, 3'd0, 7'h00, 1'b0, 0, 0);
    do_instr(OP_LH, 3'd1, 7'h00, 1'b0, 0, 3);
    do_instr(OP_BR, 3'd1, 7'h00, 1'b0, 0, 0);
    do_instr(OP_BR, 3'd1, 7'h00, 1'b1, 0, 0);
    do_instr(OP_BR, 3'd0, 7'h00, 1'b1, 0, 0);
    do_instr(7'h7F, 3'd0, 7'h00, 1'b0, 0, 0);
    do_instr(OP_R, 3'd2, 7'h00, 1'b0, 0, 0);
    do_instr(OP_SW, 3'd2, 7'h00, 1'b0, 0, 16);
    do_instr(OP_SW, 3'd2, 7'h00, 1'b0, 1, 15);
    do_instr(OP_I, 3'd7, 7'h00, 1'b0, 15, 0);
    do_instr(OP_JAL, 3'd0, 7'h00, 1'b0, 16, 0);
    for (int i = 0; i < 60; i++) rand_instr();

    // Reset in the middle of a store wait: nothing may be written or retired.
    opcode = OP_SW;
    cyc("rw_fetch", ev(S_FETCH, B_REQ | B_IRW | B_PCW, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1, 1'b0);
    cyc("rw_decode", ev(S_DECODE, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc("rw_wait", ev(S_MEM_WR, B_REQ | B_WE | B_ASRC, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 0,
          1'b0);
    rst = 1'b1;
    cyc("rw_in_rst", ev(S_MEM_WR, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1, 1'b0);
    rst = 1'b0;
    model_ret = 0;
    cyc("rw_after", ev(S_FETCH, B_REQ, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 0, 1'b0);
    check_eq("rw_retired", m_retired, 32'd0);
    cyc("rw_fetch2", ev(S_FETCH, B_REQ | B_IRW | B_PCW, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1,
        1'b0);
    cyc("rw_decode2", ev(S_DECODE, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b0);
    cyc("rw_store", ev(S_MEM_WR, B_REQ | B_WE | B_ASRC, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1,
        1'b0);
    model_ret++;
    check_eq("rw_retired2", m_retired, 32'(model_ret));
    for (int i = 0; i < 20; i++) rand_instr();

    // Terminal-trap variant on the second instance.
    rst = 1'b1;
    rst_h = 1'b0;
    opcode = 7'h7F;
    cyc("halt_fetch", ev(S_FETCH, B_REQ | B_IRW | B_PCW, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 1,
        1'b1);
    cyc("halt_decode", ev(S_DECODE, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b1);
    cyc("halt_trap", ev(S_TRAP, B_NONE, A_ADD, 1'b0, 2'b00, 1'b1, 1'b0), 2, 1'b1);
    for (int k = 0; k < 5; k++)
      cyc("halt_stay", ev(S_TRAP, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b1);
    check_eq("halt_retired", h_retired, 32'd0);
    rst_h = 1'b1;
    cyc("halt_rst", ev(S_TRAP, B_NONE, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 2, 1'b1);
    rst_h = 1'b0;
    cyc("halt_refetch", ev(S_FETCH, B_REQ, A_ADD, 1'b0, 2'b00, 1'b0, 1'b0), 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
